// File: rtl/rom_fetch_sequencer.sv
// rom_fetch_sequencer
//   Fetches one instruction from program ROM (an opcode byte followed by 0..MAX_OPERANDS
//   operand bytes, count taken from an opcode bit-field), packs it into a single word and
//   presents it to the decoder over a start/ready handshake.
//
// Ports
//   clk                 in   rising-edge clock
//   reset               in   asynchronous active-low reset
//   enable              in   permits the start of a new fetch (sampled only when idle)
//   rom_address         out  ROM byte address / program counter
//   data_from_rom       in   ROM read data, valid ROM_LATENCY cycles after an address change
//   start_for_decoder   out  instruction valid
//   ready_from_decoder  in   decoder accepts the instruction
//   data_for_decoder    out  packed instruction, opcode in the low byte
//   operand_count       out  number of operand bytes in data_for_decoder
//   pc_for_decoder      out  address of the instruction's opcode
//   halted              out  sequencer stopped after sending a HALT opcode
//
// Configuration
//   SEQ_HALT_EN  when defined, adds parameter HALT_OPCODE and a terminal halt state entered
//                after a HALT instruction is transferred; otherwise halted is tied low.

module rom_fetch_sequencer #(
    parameter int unsigned BYTE         = 8,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned MAX_OPERANDS = 2,
    parameter int unsigned OPCNT_LSB    = 6,
`ifdef SEQ_HALT_EN
    parameter logic [BYTE-1:0] HALT_OPCODE = 8'hFF,
`endif
    parameter int unsigned ROM_LATENCY  = 1
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     enable,
    output logic [ADDR_WIDTH-1:0]                    rom_address,
    input  logic [BYTE-1:0]                          data_from_rom,
    output logic                                     start_for_decoder,
    input  logic                                     ready_from_decoder,
    output logic [BYTE*(MAX_OPERANDS+1)-1:0]         data_for_decoder,
    output logic [$clog2(MAX_OPERANDS+1)-1:0]        operand_count,
    output logic [ADDR_WIDTH-1:0]                    pc_for_decoder,
    output logic                                     halted
);

    localparam int unsigned CW = $clog2(MAX_OPERANDS + 1);
    localparam int unsigned DW = BYTE * (MAX_OPERANDS + 1);
    localparam int unsigned WW = (ROM_LATENCY > 0) ? $clog2(ROM_LATENCY + 1) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(ROM_LATENCY);
    localparam logic [CW-1:0] MAX_N     = CW'(MAX_OPERANDS);

    typedef enum logic [2:0] {
        StIdle,
        StFetchOp,
        StFetchArg,
`ifdef SEQ_HALT_EN
        StSend,
        StHalt
`else
        StSend
`endif
    } state_e;

    state_e                state_q, state_d;
    logic [WW-1:0]         wait_q, wait_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] pc_start_q, pc_start_d;
    logic [DW-1:0]         buf_q, buf_d;
    logic [CW-1:0]         n_q, n_d;
    logic [CW-1:0]         arg_q, arg_d;
    logic                  start_q, start_d;
    logic [DW-1:0]         data_q, data_d;
    logic [CW-1:0]         count_q, count_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
`ifdef SEQ_HALT_EN
    logic                  halted_q, halted_d;
`endif

    logic                  byte_done;
    logic [CW-1:0]         op_field;
    logic [CW-1:0]         op_n;

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        addr_d     = addr_q;
        pc_start_d = pc_start_q;
        buf_d      = buf_q;
        n_d        = n_q;
        arg_d      = arg_q;
        start_d    = start_q;
        data_d     = data_q;
        count_d    = count_q;
        pc_d       = pc_q;
`ifdef SEQ_HALT_EN
        halted_d   = halted_q;
`endif

        // The address has been held for ROM_LATENCY+1 cycles: ROM data is valid this edge.
        byte_done = (wait_q == WAIT_LAST);
        op_field  = data_from_rom[OPCNT_LSB +: CW];
        op_n      = (op_field > MAX_N) ? MAX_N : op_field;

        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    pc_start_d = addr_q;
                    wait_d     = '0;
                    state_d    = StFetchOp;
                end
            end

            StFetchOp: begin
                if (byte_done) begin
                    wait_d = '0;
                    addr_d = addr_q + 1'b1;
                    buf_d  = DW'(data_from_rom);
                    n_d    = op_n;
                    arg_d  = '0;
                    if (op_n == '0) begin
                        state_d = StSend;
                        start_d = 1'b1;
                        data_d  = DW'(data_from_rom);
                        count_d = '0;
                        pc_d    = pc_start_q;
                    end else begin
                        state_d = StFetchArg;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            StFetchArg: begin
                if (byte_done) begin
                    wait_d = '0;
                    addr_d = addr_q + 1'b1;
                    buf_d[(int'(arg_q) + 1) * BYTE +: BYTE] = data_from_rom;
                    arg_d  = arg_q + 1'b1;
                    if (arg_q + 1'b1 == n_q) begin
                        // Publish the whole word at once so decoder outputs never show a
                        // partially assembled instruction.
                        state_d = StSend;
                        start_d = 1'b1;
                        data_d  = buf_d;
                        count_d = n_q;
                        pc_d    = pc_start_q;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            StSend: begin
                if (ready_from_decoder) begin
                    start_d = 1'b0;
                    state_d = StIdle;
`ifdef SEQ_HALT_EN
                    if (data_q[BYTE-1:0] == HALT_OPCODE) begin
                        state_d  = StHalt;
                        halted_d = 1'b1;
                    end
`endif
                end
            end

`ifdef SEQ_HALT_EN
            StHalt: begin
                state_d = StHalt;
            end
`endif

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            wait_q     <= '0;
            addr_q     <= '0;
            pc_start_q <= '0;
            buf_q      <= '0;
            n_q        <= '0;
            arg_q      <= '0;
            start_q    <= 1'b0;
            data_q     <= '0;
            count_q    <= '0;
            pc_q       <= '0;
`ifdef SEQ_HALT_EN
            halted_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            addr_q     <= addr_d;
            pc_start_q <= pc_start_d;
            buf_q      <= buf_d;
            n_q        <= n_d;
            arg_q      <= arg_d;
            start_q    <= start_d;
            data_q     <= data_d;
            count_q    <= count_d;
            pc_q       <= pc_d;
`ifdef SEQ_HALT_EN
            halted_q   <= halted_d;
`endif
        end
    end

    assign rom_address       = addr_q;
    assign start_for_decoder = start_q;
    assign data_for_decoder  = data_q;
    assign operand_count     = count_q;
    assign pc_for_decoder    = pc_q;
`ifdef SEQ_HALT_EN
    assign halted            = halted_q;
`else
    assign halted            = 1'b0;
`endif

endmodule
